// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// The slice helper keeps the port packing identical in the RTL and its users.
package regfile_pkg;

   typedef enum logic {CLEAR, READY} regfileState_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;

   function automatic int sliceOffset(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side of the register file: read ports, writeback and reservations.
// master drives addresses and writes; slave is the register file itself.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
);

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic                     init_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, init_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, init_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: set by a reservation, cleared by its writeback.
// A reservation beats a same-cycle writeback because it names the newer producer.
module regfile_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  setEn,
   input  logic [ADDR_W-1:0]     setAddr,
   input  logic                  clrEn,
   input  logic [ADDR_W-1:0]     clrAddr,
   output logic [2**ADDR_W-1:0]  pending
);

   localparam int DEPTH = 2**ADDR_W;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending <= '0;
      end else if (enable) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (setEn && setAddr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
               pending[i] <= 1'b1;
            end else if (clrEn && clrAddr == ADDR_W'(i)) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with N combinational read ports, write bypass,
// optional hardwired zero register, post-reset clear sweep and hazard scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1
) (
   input  logic          clk,
   input  logic          rst,
   regfile_mp_if.slave   bus
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   regfileState_e     state;
   logic [ADDR_W-1:0] cnt;
   logic              initBusy;
   logic              ready;
   logic [DEPTH-1:0]  pending;

   // Reset is folded in so the file reads as busy from the very first cycle of reset.
   assign initBusy      = !rst || state == CLEAR;
   assign ready         = rst && state == READY;
   assign bus.init_busy = initBusy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else if (state == CLEAR) begin
         cnt <= cnt + 1'b1;
         if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= READY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (ready && bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0)) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .enable  (ready),
      .setEn   (bus.rsv_en),
      .setAddr (bus.rsv_addr),
      .clrEn   (bus.wr_en),
      .clrAddr (bus.wr_addr),
      .pending (pending)
   );

   // Each port resolves independently; a same-cycle writeback both forwards data and clears the hazard.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              hit;

      assign addr = bus.rd_addr[sliceOffset(p, ADDR_W) +: ADDR_W];
      assign hit  = bus.wr_en && bus.wr_addr == addr;

      always_comb begin
         data = mem[addr];
         if (initBusy) begin
            data = '0;
         end else if (ZERO_REG != 0 && addr == '0) begin
            data = '0;
         end else if (hit) begin
            data = bus.wr_data;
         end
      end

      assign bus.rd_data[sliceOffset(p, DATA_W) +: DATA_W] = data;
      assign bus.rd_busy[p] = !initBusy && pending[addr] && !hit;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two instances (default 32x32/2-port with zero register, and
// 64-bit/16-entry/3-port without) driven by the same directed vectors and checked every cycle.
module tb_regfile_mp;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        wEn, rEn;
   logic [4:0]  wAddr, rsvAddr;
   logic [63:0] wData;
   logic [4:0]  rAddr [3];

   int checks  = 0;
   int passes  = 0;
   bit running = 1'b0;

   logic [63:0] mMem    [2][32];
   bit          mPend   [2][32];
   int          mRemain [2] = '{32, 16};

   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifA ();
   regfile_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) ifB ();

   assign ifA.rd_addr  = {rAddr[1], rAddr[0]};
   assign ifA.wr_en    = wEn;
   assign ifA.wr_addr  = wAddr;
   assign ifA.wr_data  = wData[31:0];
   assign ifA.rsv_en   = rEn;
   assign ifA.rsv_addr = rsvAddr;

   assign ifB.rd_addr  = {rAddr[2][3:0], rAddr[1][3:0], rAddr[0][3:0]};
   assign ifB.wr_en    = wEn;
   assign ifB.wr_addr  = wAddr[3:0];
   assign ifB.wr_data  = wData;
   assign ifB.rsv_en   = rEn;
   assign ifB.rsv_addr = rsvAddr[3:0];

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (ifA.slave)
   );

   regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (ifB.slave)
   );

   function automatic int depthOf(input int d);
      return (d == 0) ? 32 : 16;
   endfunction

   function automatic bit zeroOf(input int d);
      return d == 0;
   endfunction

   function automatic logic [63:0] maskOf(input int d);
      return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] actData(input int d, input int p);
      if (d == 0) return {32'h0, ifA.rd_data[p*32 +: 32]};
      return ifB.rd_data[p*64 +: 64];
   endfunction

   function automatic logic [63:0] actBusy(input int d, input int p);
      if (d == 0) return {63'h0, ifA.rd_busy[p]};
      return {63'h0, ifB.rd_busy[p]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // Reference behaviour: reset wipes everything and starts a DEPTH-edge busy window.
   task automatic modelEdge(input int d);
      int wa, ra;
      wa = int'(wAddr) & (depthOf(d) - 1);
      ra = int'(rsvAddr) & (depthOf(d) - 1);
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            mMem[d][i]  = '0;
            mPend[d][i] = 1'b0;
         end
         mRemain[d] = depthOf(d);
      end else if (mRemain[d] > 0) begin
         mRemain[d]--;
      end else begin
         if (wEn && !(zeroOf(d) && wa == 0)) mMem[d][wa] = wData & maskOf(d);
         if (wEn) mPend[d][wa] = 1'b0;
         if (rEn && !(zeroOf(d) && ra == 0)) mPend[d][ra] = 1'b1;
      end
   endtask

   task automatic checkOutput(input int d);
      bit          expInit, hit, expBusy;
      int          wa, a;
      logic [63:0] expData;
      expInit = !rst || mRemain[d] > 0;
      check($sformatf("d%0d init_busy", d),
            (d == 0) ? {63'h0, ifA.init_busy} : {63'h0, ifB.init_busy}, {63'h0, expInit});
      wa = int'(wAddr) & (depthOf(d) - 1);
      for (int p = 0; p < ((d == 0) ? 2 : 3); p++) begin
         a   = int'(rAddr[p]) & (depthOf(d) - 1);
         hit = wEn && wa == a;
         if (expInit)                 expData = '0;
         else if (zeroOf(d) && a == 0) expData = '0;
         else if (hit)                expData = wData & maskOf(d);
         else                         expData = mMem[d][a];
         expBusy = !expInit && mPend[d][a] && !hit;
         check($sformatf("d%0d p%0d rd_data a=%0d", d, p, a), actData(d, p), expData);
         check($sformatf("d%0d p%0d rd_busy a=%0d", d, p, a), actBusy(d, p), {63'h0, expBusy});
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) modelEdge(d);
   end

   always @(negedge clk) begin
      if (running) begin
         checkOutput(0);
         checkOutput(1);
      end
   end

   task automatic drive(input bit r, input bit w, input logic [4:0] wa, input logic [63:0] wd,
                        input bit re, input logic [4:0] ra,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      rst      = r;
      wEn      = w;
      wAddr    = wa;
      wData    = wd;
      rEn      = re;
      rsvAddr  = ra;
      rAddr[0] = a0;
      rAddr[1] = a1;
      rAddr[2] = a2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit r, input bit w, input logic [4:0] wa, input logic [63:0] wd,
                                input bit re, input logic [4:0] ra,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      drive(r, w, wa, wd, re, ra, a0, a1, a2);
      tick();
   endtask

   initial begin
      int n, nB;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
      running = 1'b1;
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2);
      check("initDuringReset", {63'h0, ifA.init_busy}, 64'd1);

      // Release reset; a write at clear edge 5 and a reservation at edge 7 must be dropped.
      n = 0;
      nB = 0;
      do begin
         applyStimulus(1, n == 4, 3, 64'hFFFF_FFFF_FFFF_FFFF, n == 6, 3, 3, 4, 3);
         n++;
         if (nB == 0 && !ifB.init_busy) nB = n;
      end while (ifA.init_busy && n < 100);
      check("clearEdgesA", 64'(n), 64'd32);
      check("clearEdgesB", 64'(nB), 64'd16);

      drive(1, 0, 0, 0, 0, 0, 3, 3, 3);
      #2;
      check("r3AfterClearA", actData(0, 0), 64'h0);
      check("r3NotPendingA", actBusy(0, 0), 64'h0);
      check("r3AfterClearB", actData(1, 2), 64'h0);
      tick();
      for (int i = 0; i < 32; i++) applyStimulus(1, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));

      applyStimulus(1, 1, 5, 64'h0123_4567_DEAD_BEEF, 0, 0, 0, 1, 2);
      drive(1, 0, 0, 0, 0, 0, 5, 5, 5);
      #2;
      check("r5Port0A", actData(0, 0), 64'hDEAD_BEEF);
      check("r5Port1A", actData(0, 1), 64'hDEAD_BEEF);
      check("r5Port2B", actData(1, 2), 64'h0123_4567_DEAD_BEEF);
      tick();

      applyStimulus(1, 1, 0, 64'h1234, 0, 0, 0, 1, 2);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("r0ZeroA", actData(0, 0), 64'h0);
      check("r0WritableB", actData(1, 0), 64'h1234);
      tick();

      applyStimulus(1, 1, 8, 64'h88, 0, 0, 0, 1, 2);
      drive(1, 1, 7, 64'h5A5A_5A5A_A5A5_A5A5, 0, 0, 7, 8, 7);
      #2;
      check("bypassP0A", actData(0, 0), 64'hA5A5_A5A5);
      check("noBypassP1A", actData(0, 1), 64'h88);
      check("bypassP0B", actData(1, 0), 64'h5A5A_5A5A_A5A5_A5A5);
      check("noBypassP1B", actData(1, 1), 64'h88);
      check("bypassP2B", actData(1, 2), 64'h5A5A_5A5A_A5A5_A5A5);
      tick();
      applyStimulus(1, 0, 0, 0, 0, 0, 7, 8, 7);

      applyStimulus(1, 0, 0, 0, 1, 9, 0, 1, 2);
      drive(1, 0, 0, 0, 0, 0, 9, 9, 9);
      #2;
      check("r9BusyP0A", actBusy(0, 0), 64'h1);
      check("r9BusyP1A", actBusy(0, 1), 64'h1);
      check("r9BusyP2B", actBusy(1, 2), 64'h1);
      tick();
      drive(1, 1, 9, 64'h99, 0, 0, 9, 9, 9);
      #2;
      check("r9WbBusyA", actBusy(0, 0), 64'h0);
      check("r9WbDataA", actData(0, 0), 64'h99);
      tick();
      applyStimulus(1, 0, 0, 0, 0, 0, 9, 9, 9);
      applyStimulus(1, 1, 9, 64'h999, 1, 9, 9, 9, 9);
      drive(1, 0, 0, 0, 0, 0, 9, 9, 9);
      #2;
      check("r9SetWinsA", actBusy(0, 0), 64'h1);
      check("r9SetWinsDataA", actData(0, 0), 64'h999);
      tick();
      applyStimulus(1, 1, 9, 64'h9, 0, 0, 9, 9, 9);

      applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("r0NeverPendingA", actBusy(0, 0), 64'h0);
      check("r0PendingB", actBusy(1, 0), 64'h1);
      tick();
      applyStimulus(1, 1, 0, 64'h77, 1, 17, 0, 17, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 17, 1);

      // Restart mid-clear: reset again after 10 clear edges.
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 9, 5);
      repeat (10) applyStimulus(1, 0, 0, 0, 0, 0, 5, 9, 5);
      check("busyAtCnt10", {63'h0, ifA.init_busy}, 64'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 9, 5);
      n = 0;
      do begin
         applyStimulus(1, 0, 0, 0, 0, 0, 5, 9, 5);
         n++;
      end while (ifA.init_busy && n < 100);
      check("restartEdgesA", 64'(n), 64'd32);
      drive(1, 0, 0, 0, 0, 0, 5, 9, 5);
      #2;
      check("r5ClearedA", actData(0, 0), 64'h0);
      check("r9ClearedBusyA", actBusy(0, 1), 64'h0);
      tick();

      running = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
